// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencer.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } mult_state_t;

  // Bits needed to hold a count from 0 up to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Saturating RUN-iteration counter with a terminal flag one step before
// the full operand width, so the FSM can leave RUN on the last iteration.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int CW          = cnt_width(WORD_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VALUE = CW'(WORD_LENGTH - 1);
  localparam logic [CW-1:0] MAX_VALUE  = CW'(WORD_LENGTH);

  // Count RUN iterations; clear wins over increment, hold at full width.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX_VALUE)) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == LAST_VALUE);

endmodule

// File: rtl/mult_control_unit.sv
// Sequencer for the shift-add multiplier: loads both shifters, steps them
// while gating accumulator adds on the multiplier LSB, and handshakes with
// the host through start/busy/done/result_valid.
module mult_control_unit
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter bit EARLY_EXIT  = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                multiplier_lsb,
  input  logic                                multiplier_zero,
  output logic                                load_enable,
  output logic                                acc_clear,
  output logic                                acc_enable,
  output logic                                busy,
  output logic                                done,
  output logic                                result_valid,
  output logic [cnt_width(WORD_LENGTH)-1:0]   iter_count
);

  mult_state_t state, state_next;
  logic        cnt_clear;
  logic        cnt_inc;
  logic        cnt_last;
  logic        early_stop;

  // Remaining multiplier bits are all zero: nothing more to add.
  assign early_stop = EARLY_EXIT && multiplier_zero;

  mult_iter_counter #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (iter_count),
    .last  (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Product stays valid from the end of DONE until the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid <= 1'b0;
    end else if (state == DONE) begin
      result_valid <= 1'b1;
    end else if ((state == IDLE) && start) begin
      result_valid <= 1'b0;
    end
  end

  // Next-state and output decode; only acc_enable looks at the inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next  = state;
    load_enable = 1'b1;
    acc_clear   = 1'b0;
    acc_enable  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        acc_clear  = 1'b1;
        cnt_clear  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        load_enable = 1'b0;
        busy        = 1'b1;
        acc_enable  = multiplier_lsb && !early_stop;
        cnt_inc     = 1'b1;
        if (cnt_last || early_stop) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
// Directed bench: three sequencers (W=8 no early exit, W=8 early exit,
// W=1 early exit), each stepping a behavioural multiplier right-shifter.
module tb_mult_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start_a;
  logic [7:0] mval [3];

  logic [2:0] le_a, clr_a, en_a, busy_a, done_a, rv_a;
  logic [3:0] ic_a [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 2) ? 1 : 8;
    localparam bit EE = (g == 0) ? 1'b0 : 1'b1;
    localparam int CW = $clog2(W + 1);

    logic          le, clr, en, bsy, dn, rv;
    logic [CW-1:0] iter_count;
    bit   [7:0]    sh;

    // Multiplier right-shifter driven by the sequencer.
    always_ff @(posedge clk) begin
      if (le) sh <= mval[g];
      else    sh <= sh >> 1;
    end

    mult_control_unit #(
      .WORD_LENGTH (W),
      .EARLY_EXIT  (EE)
    ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start_a[g]),
      .multiplier_lsb  (sh[0]),
      .multiplier_zero (sh == 8'd0),
      .load_enable     (le),
      .acc_clear       (clr),
      .acc_enable      (en),
      .busy            (bsy),
      .done            (dn),
      .result_valid    (rv),
      .iter_count      (iter_count)
    );

    assign le_a[g]   = le;
    assign clr_a[g]  = clr;
    assign en_a[g]   = en;
    assign busy_a[g] = bsy;
    assign done_a[g] = dn;
    assign rv_a[g]   = rv;
    assign ic_a[g]   = 4'(iter_count);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on instance idx; poke pulses start during RUN and DONE.
  task automatic run_op(input int idx, input logic [7:0] op, input int exp_runs,
                        input logic [7:0] exp_en, input int exp_done, input int exp_iter,
                        input bit poke, input string name);
    int         lat;
    int         runs;
    int         overlap;
    logic [7:0] en_seen;
    @(negedge clk);
    mval[idx]    = op;
    start_a[idx] = 1'b1;
    @(negedge clk);
    start_a[idx] = 1'b0;
    check({name, "_load_clr"},  32'(clr_a[idx]),  1);
    check({name, "_load_busy"}, 32'(busy_a[idx]), 1);
    check({name, "_load_rv"},   32'(rv_a[idx]),   0);
    lat = 1; runs = 0; overlap = 0; en_seen = '0;
    while (!done_a[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
      if (poke) start_a[idx] = (lat == 4);
      if (clr_a[idx] && en_a[idx]) overlap++;
      if (!done_a[idx] && !le_a[idx]) begin
        if (runs < 8) en_seen[runs] = en_a[idx];
        runs++;
      end
    end
    if (poke) start_a[idx] = 1'b1;
    check({name, "_latency"}, 32'(lat),     32'(exp_done));
    check({name, "_runs"},    32'(runs),    32'(exp_runs));
    check({name, "_en_pat"},  32'(en_seen), 32'(exp_en));
    check({name, "_iter"},    32'(ic_a[idx]), 32'(exp_iter));
    check({name, "_overlap"}, 32'(overlap), 0);
    check({name, "_done_en"}, 32'(en_a[idx]), 0);
    @(negedge clk);
    start_a[idx] = 1'b0;
    check({name, "_done_pulse"}, 32'(done_a[idx]), 0);
    check({name, "_rv"},         32'(rv_a[idx]),   1);
    check({name, "_idle_busy"},  32'(busy_a[idx]), 0);
    check({name, "_iter_hold"},  32'(ic_a[idx]),   32'(exp_iter));
    @(negedge clk);
    check({name, "_no_restart"}, 32'(busy_a[idx]), 0);
  endtask

  initial begin
    int lat;
    int nd;
    int nclr;
    int d [3];

    reset   = 1'b0;
    start_a = '0;
    for (int i = 0; i < 3; i++) mval[i] = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_le", i),   32'(le_a[i]),   1);
      check($sformatf("rst%0d_busy", i), 32'(busy_a[i]), 0);
      check($sformatf("rst%0d_done", i), 32'(done_a[i]), 0);
      check($sformatf("rst%0d_rv", i),   32'(rv_a[i]),   0);
      check($sformatf("rst%0d_clr", i),  32'(clr_a[i]),  0);
      check($sformatf("rst%0d_en", i),   32'(en_a[i]),   0);
      check($sformatf("rst%0d_iter", i), 32'(ic_a[i]),   0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Full-length run: B5 LSB-first is 1,0,1,0,1,1,0,1.
    run_op(0, 8'hB5, 8, 8'hB5, 10, 8, 1'b0, "t1");
    // Early exit after the last set bit, and on a zero multiplier.
    run_op(1, 8'h03, 3, 8'h03, 5, 3, 1'b0, "t2");
    run_op(1, 8'h00, 1, 8'h00, 3, 1, 1'b0, "t3");
    // Single-bit operand width.
    run_op(2, 8'h01, 1, 8'h01, 3, 1, 1'b0, "t6_w1a");
    run_op(2, 8'h02, 1, 8'h00, 3, 1, 1'b0, "t6_w1b");
    // start pulses during RUN and DONE must be ignored.
    run_op(0, 8'h00, 8, 8'h00, 10, 8, 1'b1, "t6_poke");

    // start held high: three back-to-back operations.
    @(negedge clk);
    mval[0]    = 8'h81;
    start_a[0] = 1'b1;
    lat = 0; nd = 0; nclr = 0;
    for (int i = 0; i < 3; i++) d[i] = 0;
    while (nd < 3 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (clr_a[0]) nclr++;
      if (done_a[0]) begin
        d[nd] = lat;
        nd++;
      end
    end
    start_a[0] = 1'b0;
    check("t4_ndone",  32'(nd),          3);
    check("t4_first",  32'(d[0]),        10);
    check("t4_gap1",   32'(d[1] - d[0]), 11);
    check("t4_gap2",   32'(d[2] - d[1]), 11);
    check("t4_nclr",   32'(nclr),        3);
    @(negedge clk);
    @(negedge clk);
    check("t4_stop",   32'(busy_a[0]),   0);

    // Reset asserted in the 4th RUN cycle.
    @(negedge clk);
    mval[0]    = 8'hB5;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_pre_iter", 32'(ic_a[0]),   3);
    check("t5_pre_busy", 32'(busy_a[0]), 1);
    reset = 1'b0;
    #1;
    check("t5_busy", 32'(busy_a[0]), 0);
    check("t5_le",   32'(le_a[0]),   1);
    check("t5_iter", 32'(ic_a[0]),   0);
    check("t5_rv",   32'(rv_a[0]),   0);
    check("t5_en",   32'(en_a[0]),   0);
    check("t5_clr",  32'(clr_a[0]),  0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 8'hB5, 8, 8'hB5, 10, 8, 1'b0, "t5_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
